cpc_rom_loader: RTL and testbench

//  Parametrised ROM/expansion download engine between hps_io ioctl stream and SDRAM port.

---
 rtl/cpc_rom_loader.sv | 279 +++++++++++++++++++++++++++
 tb/tb_cpc_rom_loader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpc_rom_loader.sv
// cpc_rom_loader: moves hps_io ioctl download bytes into SDRAM for the CPC core.
// Each byte is mapped to a 16 KB page (boot image slots or named eXX/ZZ/Z0
// expansion files) and is written to one or more SDRAM banks, with writes
// paced by the SDRAM reference strobe. The host is held off with dl_wait.
// A per-page map records which upper-ROM pages hold a loaded image.
// Optional feature: define CPC_ROM_LOADER_CSUM_EN for a 16-bit byte checksum.
module cpc_rom_loader #(
    parameter int BANKS    = 2,
    parameter int PAGE_W   = 9,
    parameter int ADDR_W   = 23,
    parameter int MAP_SIZE = 256,
    localparam int BANK_W  = (BANKS > 1) ? $clog2(BANKS) : 1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce_ref,
    input  logic                dl_active,
    input  logic                dl_wr,
    input  logic [24:0]         dl_addr,
    input  logic [7:0]          dl_data,
    input  logic [7:0]          dl_index,
    input  logic [15:0]         dl_ext,
    input  logic [BANKS-1:0]    bank_mask,
    input  logic                map_clr,
    output logic                dl_wait,
    output logic                mem_wr,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [BANK_W-1:0]   mem_bank,
    output logic [7:0]          mem_din,
    output logic [MAP_SIZE-1:0] rom_map,
    output logic                busy,
    output logic [15:0]         csum
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARM   = 2'd1,
        S_WRITE = 2'd2,
        S_NEXT  = 2'd3
    } state_t;

    // Decode one ASCII hex digit ('0'-'9', 'A'-'F'); bit 4 flags a valid digit.
    function automatic logic [4:0] hex_nib(input logic [7:0] c);
        logic [4:0] r;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, 4'(c - 8'h30)};
        end else if (c >= 8'h41 && c <= 8'h46) begin
            r = {1'b1, 4'(c - 8'h37)};
        end else begin
            r = 5'h00;
        end
        return r;
    endfunction

    // Lowest set bit of a bank mask; bank writes go out in ascending order.
    function automatic logic [BANK_W-1:0] first_bank(input logic [BANKS-1:0] m);
        logic [BANK_W-1:0] r;
        r = {BANK_W{1'b0}};
        for (int i = BANKS - 1; i >= 0; i--) begin
            if (m[i]) begin
                r = BANK_W'(i);
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    state_t                state_q, state_d;
    logic                  dl_active_q, dl_active_d;
    logic [PAGE_W-1:0]     base_q, base_d;
    logic                  combo_q, combo_d;
    logic [BANKS-1:0]      pend_q, pend_d;
    logic [7:0]            file_pg_q, file_pg_d;
    logic                  dl_wait_q, dl_wait_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [BANK_W-1:0]     mem_bank_q, mem_bank_d;
    logic [7:0]            mem_din_q, mem_din_d;
    logic [MAP_SIZE-1:0]   rom_map_q, rom_map_d;

    logic                  rise_s;
    logic [10:0]           slot_s;
    logic                  boot_ok_s;
    logic                  accept_s;
    logic [PAGE_W-1:0]     boot_page_s;
    logic [BANK_W-1:0]     boot_bank_s;
    logic [PAGE_W-1:0]     exp_page_s;
    logic [BANKS-1:0]      exp_mask_s;
    logic [BANK_W-1:0]     exp_first_s;
    logic [BANK_W-1:0]     nxt_first_s;
    logic [4:0]            hi_s;
    logic [4:0]            lo_s;

    assign rise_s      = dl_active & ~dl_active_q;
    assign slot_s      = dl_addr[24:14];
    assign boot_ok_s   = (32'(slot_s) < 32'(4 * BANKS));
    assign boot_bank_s = BANK_W'(slot_s >> 2);
    assign accept_s    = (state_q == S_IDLE) && dl_wr && ((dl_index != 8'h00) || boot_ok_s);
    assign exp_page_s  = {base_q[PAGE_W-1:8], base_q[7:0] + dl_addr[21:14]};
    assign exp_mask_s  = (bank_mask == {BANKS{1'b0}}) ? BANKS'(1'b1) : bank_mask;
    assign exp_first_s = first_bank(exp_mask_s);
    assign nxt_first_s = first_bank(pend_q);
    assign hi_s        = hex_nib(dl_ext[15:8]);
    assign lo_s        = hex_nib(dl_ext[7:0]);

    // Boot slot to page: lower RAM, upper ROM 0, AMSDOS (7) and the top page.
    always_comb begin
        case (slot_s[1:0])
            2'd0:    boot_page_s = PAGE_W'(9'h000);
            2'd1:    boot_page_s = PAGE_W'(9'h100);
            2'd2:    boot_page_s = PAGE_W'(9'h107);
            default: boot_page_s = PAGE_W'(9'h1FF);
        endcase
    end

    // Next-state logic for the download FSM, page base and ROM map.
    always_comb begin
        state_d     = state_q;
        dl_active_d = dl_active;
        base_d      = base_q;
        combo_d     = combo_q;
        pend_d      = pend_q;
        file_pg_d   = file_pg_q;
        dl_wait_d   = dl_wait_q;
        mem_wr_d    = mem_wr_q;
        mem_addr_d  = mem_addr_q;
        mem_bank_d  = mem_bank_q;
        mem_din_d   = mem_din_q;
        // A set on completion below overrides a concurrent clear.
        rom_map_d   = map_clr ? {MAP_SIZE{1'b0}} : rom_map_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d   = S_ARM;
                    dl_wait_d = 1'b1;
                    mem_din_d = dl_data;
                    file_pg_d = dl_addr[21:14];
                    if (dl_index == 8'h00) begin
                        mem_addr_d = ADDR_W'({boot_page_s, dl_addr[13:0]});
                        mem_bank_d = boot_bank_s;
                        pend_d     = {BANKS{1'b0}};
                    end else begin
                        mem_addr_d = ADDR_W'({exp_page_s, dl_addr[13:0]});
                        mem_bank_d = exp_first_s;
                        pend_d     = exp_mask_s & ~(BANKS'(1'b1) << exp_first_s);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (ce_ref) begin
                    mem_wr_d = 1'b1;
                    state_d  = S_WRITE;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_WRITE: begin
                if (ce_ref) begin
                    mem_wr_d = 1'b0;
                    if (pend_q != {BANKS{1'b0}}) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d   = S_IDLE;
                        dl_wait_d = 1'b0;
                        if (mem_addr_q[ADDR_W-1] && !reset && (32'(mem_addr_q[21:14]) < 32'(MAP_SIZE))) begin
                            rom_map_d[mem_addr_q[21:14]] = 1'b1;
                        end else begin
                            rom_map_d = rom_map_d;
                        end
                        // Combo file: the following 16 KB page goes to upper ROM 0xFF.
                        if (combo_q && (mem_addr_q[13:0] == 14'h3FFF)) begin
                            base_d  = PAGE_W'(9'h100) | PAGE_W'(8'hFE - file_pg_q);
                            combo_d = 1'b0;
                        end else begin
                            combo_d = combo_q;
                        end
                    end
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_NEXT: begin
                mem_bank_d = nxt_first_s;
                pend_d     = pend_q & ~(BANKS'(1'b1) << nxt_first_s);
                state_d    = S_ARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new download selects the page base from the file extension.
        if (rise_s) begin
            if (dl_index != 8'h00) begin
                if (dl_ext == 16'h5A5A) begin
                    base_d  = {PAGE_W{1'b0}};
                    combo_d = 1'b0;
                end else if (dl_ext == 16'h5A30) begin
                    base_d  = {PAGE_W{1'b0}};
                    combo_d = 1'b1;
                end else begin
                    base_d      = PAGE_W'(9'h1EE);
                    base_d[7:4] = hi_s[4] ? hi_s[3:0] : 4'hE;
                    base_d[3:0] = lo_s[4] ? lo_s[3:0] : 4'hE;
                    combo_d     = 1'b0;
                end
            end else begin
                combo_d = 1'b0;
            end
        end else begin
            dl_active_d = dl_active;
        end
    end

    // State and output registers; the ROM map survives reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dl_active_q <= 1'b0;
            base_q      <= {PAGE_W{1'b0}};
            combo_q     <= 1'b0;
            pend_q      <= {BANKS{1'b0}};
            file_pg_q   <= 8'h00;
            dl_wait_q   <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_bank_q  <= {BANK_W{1'b0}};
            mem_din_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            dl_active_q <= dl_active_d;
            base_q      <= base_d;
            combo_q     <= combo_d;
            pend_q      <= pend_d;
            file_pg_q   <= file_pg_d;
            dl_wait_q   <= dl_wait_d;
            mem_wr_q    <= mem_wr_d;
            mem_addr_q  <= mem_addr_d;
            mem_bank_q  <= mem_bank_d;
            mem_din_q   <= mem_din_d;
        end
        rom_map_q <= rom_map_d;
    end

`ifdef CPC_ROM_LOADER_CSUM_EN
    logic [15:0] csum_q, csum_d;

    // Running byte sum, restarted at the start of every download.
    always_comb begin
        csum_d = (rise_s ? 16'h0000 : csum_q) + (accept_s ? {8'h00, dl_data} : 16'h0000);
    end

    // Checksum register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            csum_q <= 16'h0000;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`else
    assign csum = 16'h0000;
`endif

    assign dl_wait  = dl_wait_q;
    assign mem_wr   = mem_wr_q;
    assign mem_addr = mem_addr_q;
    assign mem_bank = mem_bank_q;
    assign mem_din  = mem_din_q;
    assign rom_map  = rom_map_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpc_rom_loader.sv
`timescale 1ns/1ps
// Bench for cpc_rom_loader: directed spec scenarios plus random bytes,
// checked against a page/bank reference model kept in the bench.
module tb_cpc_rom_loader;
    localparam int BANKS = 2;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ce_ref = 1'b0;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = 25'd0;
    logic [7:0]  dl_data = 8'd0;
    logic [7:0]  dl_index = 8'd0;
    logic [15:0] dl_ext = 16'd0;
    logic [1:0]  bank_mask = 2'd0;
    logic        map_clr = 1'b0;
    logic        dl_wait, mem_wr, busy;
    logic [22:0] mem_addr;
    logic [0:0]  mem_bank;
    logic [7:0]  mem_din;
    logic [255:0] rom_map;
    logic [15:0] csum;

    cpc_rom_loader dut (
        .clk_sys(clk_sys), .reset(reset), .ce_ref(ce_ref), .dl_active(dl_active),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_index(dl_index),
        .dl_ext(dl_ext), .bank_mask(bank_mask), .map_clr(map_clr), .dl_wait(dl_wait),
        .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_bank(mem_bank), .mem_din(mem_din),
        .rom_map(rom_map), .busy(busy), .csum(csum)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_bad = 0;
    int stab_err = 0;
    int pulse_err = 0;
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];

    // reference model state
    int m_base = 0;
    int m_sw = 0;
    bit m_combo = 1'b0;
    bit m_switched = 1'b0;
    logic [255:0] m_map = 256'd0;
    logic [15:0] m_csum = 16'd0;

    function automatic logic [63:0] pack(input int bank, input int addr, input logic [7:0] d);
        return {25'd0, 8'(bank), 23'(addr), d};
    endfunction

    function automatic int hexval(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
        if (c >= 8'h41 && c <= 8'h46) return int'(c) - 55;
        return -1;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SDRAM reference strobe with irregular spacing
    initial begin
        forever begin
            @(negedge clk_sys);
            ce_ref = ($urandom_range(0, 2) == 0);
        end
    end

    // write monitor: logs each write pulse, checks pacing and stability
    initial begin : mon
        logic prev;
        logic [63:0] cur, now_p;
        prev = 1'b0;
        cur = 64'd0;
        forever begin
            @(posedge clk_sys); #1;
            now_p = {25'd0, 8'(mem_bank), mem_addr, mem_din};
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (mem_wr && !prev) begin
                    if (!ce_ref) pulse_err++;
                    cur = now_p;
                    obs_q.push_back(now_p);
                end else if (mem_wr && prev) begin
                    if (ce_ref) pulse_err++;
                    if (now_p !== cur) stab_err++;
                end else if (!mem_wr && prev) begin
                    if (!ce_ref) pulse_err++;
                end
                prev = mem_wr;
            end
        end
    end

    task automatic compare_writes();
        int n;
        check("nwrites", 256'(obs_q.size()), 256'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check("write", 256'(obs_q[i]), 256'(exp_q[i]));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic start_dl(input logic [7:0] idx, input logic [15:0] ext);
        int hi, lo;
        @(negedge clk_sys);
        dl_active = 1'b0;
        @(negedge clk_sys);
        dl_index = idx;
        dl_ext = ext;
        dl_active = 1'b1;
        @(negedge clk_sys);
        m_csum = 16'd0;
        m_switched = 1'b0;
        m_combo = 1'b0;
        if (idx != 8'd0) begin
            if (ext == 16'h5A5A) m_base = 0;
            else if (ext == 16'h5A30) begin m_base = 0; m_combo = 1'b1; end
            else begin
                hi = hexval(ext[15:8]);
                lo = hexval(ext[7:0]);
                m_base = 256 + 16 * ((hi < 0) ? 14 : hi) + ((lo < 0) ? 14 : lo);
            end
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d, input bit extra);
        int pg, s, apg, msk;
        bit acc, fin;
        apg = int'(a[21:14]);
        pg = 0;
        if (dl_index == 8'd0) begin
            s = int'(a[24:14]);
            acc = (s < 4 * BANKS);
            case (s % 4)
                0: pg = 0;
                1: pg = 256;
                2: pg = 263;
                default: pg = 511;
            endcase
            if (acc) exp_q.push_back(pack(s / 4, pg * 16384 + int'(a[13:0]), d));
        end else begin
            acc = 1'b1;
            if (m_switched) pg = 256 + ((511 + apg - m_sw) % 256);
            else pg = (m_base / 256) * 256 + ((m_base % 256) + apg) % 256;
            msk = (bank_mask == 2'd0) ? 1 : int'(bank_mask);
            for (int b = 0; b < BANKS; b++)
                if (((msk >> b) & 1) == 1) exp_q.push_back(pack(b, pg * 16384 + int'(a[13:0]), d));
        end
        if (acc && pg >= 256) m_map[pg - 256] = 1'b1;
        if (acc && m_combo && a[13:0] == 14'h3FFF) begin
            m_switched = 1'b1;
            m_sw = apg + 1;
            m_combo = 1'b0;
        end
`ifdef CPC_ROM_LOADER_CSUM_EN
        if (acc) m_csum = m_csum + {8'd0, d};
`endif
        @(negedge clk_sys);
        dl_wr = 1'b1;
        dl_addr = a;
        dl_data = d;
        @(posedge clk_sys); #1;
        check("wait_rise", 256'(dl_wait), 256'(acc));
        check("busy_rise", 256'(busy), 256'(acc));
        @(negedge clk_sys);
        if (extra) begin
            dl_addr = a ^ 25'h0000100;
            dl_data = ~d;
            @(negedge clk_sys);
        end
        dl_wr = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 400 && !fin; i++) begin
            if (!busy && !dl_wait) fin = 1'b1;
            else begin @(posedge clk_sys); #1; end
        end
        check("done_in_time", 256'(fin), 256'(1));
        compare_writes();
        check("rom_map", rom_map, m_map);
        check("csum", 256'(csum), 256'(m_csum));
    endtask

    initial begin
        string hx;
        logic [15:0] ext;
        bit fin;
        hx = "0123456789ABCDEFQZ";

        // reset, with a map clear to establish a known map
        repeat (3) @(negedge clk_sys);
        map_clr = 1'b1;
        @(negedge clk_sys);
        map_clr = 1'b0;
        @(posedge clk_sys); #1;
        check("rst_dl_wait", 256'(dl_wait), 256'(0));
        check("rst_mem_wr", 256'(mem_wr), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_mem_addr", 256'(mem_addr), 256'(0));
        check("rst_mem_bank", 256'(mem_bank), 256'(0));
        check("rst_mem_din", 256'(mem_din), 256'(0));
        check("rst_csum", 256'(csum), 256'(0));
        check("rst_rom_map", rom_map, 256'd0);
        @(negedge clk_sys);
        reset = 1'b0;

        // boot image: byte at 0x4000 -> page 0x100 bank 0
        start_dl(8'h00, 16'h0000);
        send_byte(25'h0004000, 8'hA5, 1'b0);
        check("boot_addr", 256'(mem_addr), 256'(23'h400000));
        check("boot_bank", 256'(mem_bank), 256'(0));
        check("boot_din", 256'(mem_din), 256'(8'hA5));
        // slot 8 is beyond two banks: discarded
        send_byte(25'h0020000, 8'h11, 1'b0);
        check("discard_addr", 256'(mem_addr), 256'(23'h400000));
        for (int r = 0; r < 10; r++)
            send_byte(25'($urandom_range(0, 9) * 16384 + $urandom_range(0, 16383)), 8'($urandom), 1'b0);

        // "e07" into both banks; a second dl_wr while busy must be ignored
        start_dl(8'h01, 16'h3037);
        bank_mask = 2'b11;
        send_byte(25'h0000010, 8'h5A, 1'b1);
        check("e07_addr", 256'(mem_addr), 256'(23'h41C010));
        check("e07_bank", 256'(mem_bank), 256'(1));
        check("e07_map7", 256'(rom_map[7]), 256'(1));

        // "eQ1": invalid hi char keeps E
        start_dl(8'h01, 16'h5131);
        bank_mask = 2'b01;
        send_byte(25'h0000123, 8'h77, 1'b0);
        check("eq1_addr", 256'(mem_addr), 256'({9'h1E1, 14'h0123}));

        // "ZZ": lower RAM page 0
        start_dl(8'h02, 16'h5A5A);
        bank_mask = 2'b00;
        send_byte(25'h0000200, 8'h42, 1'b0);
        check("zz_page", 256'(mem_addr[22:14]), 256'(0));

        // "Z0": 32 KB combo file
        start_dl(8'h03, 16'h5A30);
        bank_mask = 2'b10;
        send_byte(25'h0000000, 8'h01, 1'b0);
        send_byte(25'h0003FFF, 8'h02, 1'b0);
        check("z0_first_page", 256'(mem_addr[22:14]), 256'(0));
        send_byte(25'h0004000, 8'h03, 1'b0);
        check("z0_second_page", 256'(mem_addr[22:14]), 256'(9'h1FF));
        send_byte(25'h0007FFF, 8'h04, 1'b0);

        // random expansion files and bank masks
        for (int f = 0; f < 5; f++) begin
            ext = {hx[$urandom_range(0, 17)], hx[$urandom_range(0, 17)]};
            start_dl(8'($urandom_range(1, 255)), ext);
            for (int k = 0; k < 4; k++) begin
                bank_mask = 2'($urandom_range(0, 3));
                send_byte(25'($urandom), 8'($urandom), 1'b0);
            end
        end

        // clear held across a completion: the completing set wins
        start_dl(8'h01, 16'h3343);
        bank_mask = 2'b01;
        @(negedge clk_sys);
        map_clr = 1'b1;
        m_map = 256'd0;
        send_byte(25'h0000100, 8'h99, 1'b0);
        @(negedge clk_sys);
        map_clr = 1'b0;
        @(negedge clk_sys);
        check("clr_vs_set", rom_map, m_map);

        // reset in the middle of a write
        start_dl(8'h00, 16'h0000);
        exp_q.push_back(pack(0, 263 * 16384 + 5, 8'h3C));
        @(negedge clk_sys);
        dl_wr = 1'b1;
        dl_addr = 25'h0008005;
        dl_data = 8'h3C;
        @(negedge clk_sys);
        dl_wr = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            if (mem_wr) fin = 1'b1;
            else @(negedge clk_sys);
        end
        check("rst_wr_seen", 256'(fin), 256'(1));
        reset = 1'b1;
        @(posedge clk_sys); #1;
        check("abort_mem_wr", 256'(mem_wr), 256'(0));
        check("abort_dl_wait", 256'(dl_wait), 256'(0));
        check("abort_busy", 256'(busy), 256'(0));
        @(negedge clk_sys);
        reset = 1'b0;
        m_base = 0;
        m_combo = 1'b0;
        m_switched = 1'b0;
        m_csum = 16'd0;
        compare_writes();
        check("map_kept", rom_map, m_map);
        @(negedge clk_sys);
        map_clr = 1'b1;
        @(negedge clk_sys);
        map_clr = 1'b0;
        check("map_cleared", rom_map, 256'd0);

        check("pulse_pacing", 256'(pulse_err), 256'(0));
        check("write_stable", 256'(stab_err), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
